// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the program loader.
package loader_pkg;

  localparam logic [7:0] CMD_INS = 8'hA5;
  localparam logic [7:0] CMD_DAT = 8'h5A;
  localparam logic [7:0] CMD_RUN = 8'h0F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CNT,
    PAYLOAD,
    WHOLD,
    CKSUM
  } state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian word assembler and running modulo-256 checksum.
// word/word_valid are combinational so the word is usable on the edge
// that accepts its 4th byte.
module loader_word_asm (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        sum_en,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [7:0]  sum
);

  logic [1:0]      idx_reg;
  logic [2:0][7:0] lane_reg;
  logic [2:0][7:0] lane_next;
  logic [7:0]      sum_reg;

  // Only the low three lanes are stored; the top byte is taken live.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_next[gi] = (shift_en && idx_reg == 2'(gi)) ? byte_in : lane_reg[gi];
    end
  endgenerate

  // Byte index, stored lanes and checksum; clear starts a new frame.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      idx_reg  <= 2'd0;
      lane_reg <= '0;
      sum_reg  <= 8'd0;
    end else begin
      lane_reg <= lane_next;
      if (shift_en) idx_reg <= idx_reg + 2'd1;
      if (sum_en)   sum_reg <= sum_reg + byte_in;
    end
  end

  assign word_valid = shift_en && (idx_reg == 2'd3);
  assign word       = {byte_in, lane_reg[2], lane_reg[1], lane_reg[0]};
  assign sum        = sum_reg;

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader feeding the core's instruction/data memory
// write ports and gating the core's reset until a run command arrives.
module program_loader
  import loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int WR_HOLD     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        write_ins,
  output logic [7:0]  addr_ins,
  output logic [31:0] dati_ins,
  output logic        write_data,
  output logic [7:0]  addr_data,
  output logic [31:0] dati_data,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int HD_W = $clog2(WR_HOLD + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(WR_HOLD - 1);

  state_t          state_reg, state_next;
  logic            live_reg;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic [HD_W-1:0] hold_reg, hold_next;
  logic [7:0]      addr_reg, addr_next;
  logic [8:0]      words_reg, words_next;
  logic            is_ins_reg, is_ins_next;
  logic [7:0]      addr_ins_reg, addr_ins_next, addr_data_reg, addr_data_next;
  logic [31:0]     dati_ins_reg, dati_ins_next, dati_data_reg, dati_data_next;
  logic            core_rst_n_reg, core_rst_n_next;
  logic            done_reg, done_next, err_reg, err_next;

  logic        accept, is_load_cmd, timed;
  logic        asm_clear, sum_en, shift_en, word_valid;
  logic [31:0] asm_word;
  logic [7:0]  asm_sum;

  assign rx_ready    = live_reg && (state_reg != WHOLD);
  assign accept      = rx_valid && rx_ready;
  assign is_load_cmd = (rx_data == CMD_INS) || (rx_data == CMD_DAT);
  assign timed       = (state_reg == ADDR) || (state_reg == CNT) ||
                       (state_reg == PAYLOAD) || (state_reg == CKSUM);
  assign asm_clear   = accept && (state_reg == IDLE) && is_load_cmd;
  assign sum_en      = accept && ((state_reg == ADDR) || (state_reg == CNT) ||
                                  (state_reg == PAYLOAD));
  assign shift_en    = accept && (state_reg == PAYLOAD);

  loader_word_asm u_word_asm (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (asm_clear),
    .sum_en     (sum_en),
    .shift_en   (shift_en),
    .byte_in    (rx_data),
    .word       (asm_word),
    .word_valid (word_valid),
    .sum        (asm_sum)
  );

  // Next-state logic: frame parsing, write hold, checksum verdict, timeout.
  always_comb begin
    state_next      = state_reg;
    to_cnt_next     = to_cnt_reg;
    hold_next       = hold_reg;
    addr_next       = addr_reg;
    words_next      = words_reg;
    is_ins_next     = is_ins_reg;
    addr_ins_next   = addr_ins_reg;
    dati_ins_next   = dati_ins_reg;
    addr_data_next  = addr_data_reg;
    dati_data_next  = dati_data_reg;
    core_rst_n_next = core_rst_n_reg;
    done_next       = 1'b0;
    err_next        = err_reg;

    case (state_reg)
      IDLE: begin
        to_cnt_next = '0;
        if (accept) begin
          err_next = 1'b0;
          if (is_load_cmd) begin
            is_ins_next     = (rx_data == CMD_INS);
            core_rst_n_next = 1'b0;
            state_next      = ADDR;
          end else if (rx_data == CMD_RUN) begin
            core_rst_n_next = 1'b1;
          end
        end
      end
      ADDR: if (accept) begin
        addr_next  = rx_data;
        state_next = CNT;
      end
      CNT: if (accept) begin
        // A count byte of zero stands for a full 256-word page.
        words_next = {(rx_data == 8'd0), rx_data};
        state_next = PAYLOAD;
      end
      PAYLOAD: if (word_valid) begin
        if (is_ins_reg) begin
          addr_ins_next = addr_reg;
          dati_ins_next = asm_word;
        end else begin
          addr_data_next = addr_reg;
          dati_data_next = asm_word;
        end
        hold_next  = '0;
        state_next = WHOLD;
      end
      WHOLD: begin
        if (hold_reg == HD_LAST) begin
          addr_next  = addr_reg + 8'd1;
          words_next = words_reg - 9'd1;
          state_next = (words_reg == 9'd1) ? CKSUM : PAYLOAD;
        end else begin
          hold_next = hold_reg + HD_W'(1);
        end
      end
      CKSUM: if (accept) begin
        if (rx_data == asm_sum) done_next = 1'b1;
        else                    err_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (timed) begin
      if (accept) begin
        to_cnt_next = '0;
      end else if (to_cnt_reg == TO_LAST) begin
        to_cnt_next = '0;
        err_next    = 1'b1;
        state_next  = IDLE;
      end else begin
        to_cnt_next = to_cnt_reg + TO_W'(1);
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      live_reg       <= 1'b0;
      to_cnt_reg     <= '0;
      hold_reg       <= '0;
      addr_reg       <= 8'd0;
      words_reg      <= 9'd0;
      is_ins_reg     <= 1'b0;
      addr_ins_reg   <= 8'd0;
      dati_ins_reg   <= 32'd0;
      addr_data_reg  <= 8'd0;
      dati_data_reg  <= 32'd0;
      core_rst_n_reg <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      live_reg       <= 1'b1;
      to_cnt_reg     <= to_cnt_next;
      hold_reg       <= hold_next;
      addr_reg       <= addr_next;
      words_reg      <= words_next;
      is_ins_reg     <= is_ins_next;
      addr_ins_reg   <= addr_ins_next;
      dati_ins_reg   <= dati_ins_next;
      addr_data_reg  <= addr_data_next;
      dati_data_reg  <= dati_data_next;
      core_rst_n_reg <= core_rst_n_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
    end
  end

  assign write_ins  = (state_reg == WHOLD) && is_ins_reg;
  assign write_data = (state_reg == WHOLD) && !is_ins_reg;
  assign addr_ins   = addr_ins_reg;
  assign dati_ins   = dati_ins_reg;
  assign addr_data  = addr_data_reg;
  assign dati_data  = dati_data_reg;
  assign core_rst_n = core_rst_n_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream loader that sits directly upstream of the RISC-V core's external memory-load ports.
- Receives framed bytes over a valid/ready handshake and assembles little-endian 32-bit words.
- Drives the core's instruction-memory write port (write_ins/addr_ins/dati_ins) and data-memory write port (write_data/addr_data/dati_data).
- Gates the core's reset_n (core_rst_n) so the core runs only after an explicit run command.

Parameters:
- TIMEOUT_CYC, 1024: idle cycles allowed between accepted bytes inside a frame before abort.
- WR_HOLD, 2: cycles each write strobe is held. Must be ≥2 because data memory is clocked at half rate.

Ports:
- clock, in, 1: system clock (same clock as the core).
- reset_n, in, 1: synchronous, active-low reset.
- rx_data, in, 8: incoming byte.
- rx_valid, in, 1: rx_data valid.
- rx_ready, out, 1: loader can accept a byte. Accept = rx_valid & rx_ready.
- write_ins, out, 1: instruction-memory write strobe.
- addr_ins, out, 8: instruction-memory word address.
- dati_ins, out, 32: instruction-memory write data.
- write_data, out, 1: data-memory write strobe.
- addr_data, out, 8: data-memory word address.
- dati_data, out, 32: data-memory write data.
- core_rst_n, out, 1: drives the core's reset_n. 0 holds the core.
- busy, out, 1: frame in progress (state != IDLE).
- done, out, 1: one-cycle pulse when a frame completes with a good checksum.
- err, out, 1: sticky error flag, cleared on the next accepted command byte.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - rx_ready=0; all strobes, addresses and data = 0; core_rst_n=0; busy=0; done=0; err=0; state=IDLE.
  - Reset mid-frame aborts the frame. No further strobes are issued.
- Outside reset: rx_ready=1 except during write-hold cycles.
- Frame format: CMD, ADDR, CNT, then 4*N payload bytes (LSB first), then CKSUM.
  - N = CNT; CNT=0 means 256 words.
  - CKSUM = 8-bit modulo-256 sum of all bytes after CMD, up to and excluding CKSUM.
- Commands (accepted only in IDLE):
  - 0xA5: load instruction memory.
  - 0x5A: load data memory.
  - 0x0F: run. core_rst_n=1 from the next cycle; state stays IDLE; no done pulse.
  - Any other byte: discarded silently (resync); err cleared.
- Accepting 0xA5 or 0x5A forces core_rst_n=0 on the next cycle and clears err.
- FSM states:
  - IDLE -(load cmd)-> ADDR -> CNT -> PAYLOAD -> CKSUM -> IDLE.
  - PAYLOAD -> WHOLD -> PAYLOAD or CKSUM.
- PAYLOAD:
  - Byte counter 0..3 shifts bytes into word[8*k +: 8].
  - On the 4th byte, go to WHOLD.
- WHOLD:
  - Target strobe high for exactly WR_HOLD cycles, starting the cycle after the 4th byte is accepted.
  - Address and data stay stable for the whole hold, and stay stable after it until the next word.
  - rx_ready=0 throughout the hold.
  - Non-target strobe stays 0.
- After each hold: address += 1, wrapping 0xFF→0x00; remaining-word count -= 1. Count reaching 0 → CKSUM, else → PAYLOAD.
- CKSUM byte accepted:
  - Match: done=1 for one cycle; err unchanged (0).
  - Mismatch: err=1, no done pulse.
  - Either way, go to IDLE. Words already written are not rolled back.
- Timeout:
  - Counter runs in ADDR, CNT, PAYLOAD and CKSUM; reloads on every accepted byte; frozen in WHOLD.
  - At TIMEOUT_CYC idle cycles: err=1, go to IDLE, no done.
  - core_rst_n stays 0.
- busy is combinational from state.

Decomposition:
- loader_pkg holds: command constants (CMD_INS=0xA5, CMD_DAT=0x5A, CMD_RUN=0x0F) and the state encoding (IDLE, ADDR, CNT, PAYLOAD, WHOLD, CKSUM).
- One sub-module, loader_word_asm: byte shifter, byte index 0..3, word_valid pulse and running checksum, with a clear input.
- Top level holds the FSM, timeout counter, address/count registers and strobe-hold counter.

Test Plan:
1. Instruction load:
   - Stimulus: A5 10 01 13 00 00 00 24.
   - Response: write_ins=1 for 2 cycles with addr_ins=0x10 and dati_ins=0x00000013; write_data stays 0; done pulses once; core_rst_n stays 0.
2. Data load with address wrap:
   - Stimulus: 5A FF 02 44 33 22 11 88 77 66 55 65.
   - Response: write_data at addr 0xFF with 0x11223344, then at addr 0x00 with 0x55667788; done=1.
3. Run and re-hold:
   - Stimulus: 0F, then later A5.
   - Response: core_rst_n=1 the cycle after 0F is accepted; core_rst_n=0 the cycle after A5 is accepted.
4. Bad checksum:
   - Stimulus: case 1 with CKSUM=0x25.
   - Response: the write still occurs; err=1; done=0; busy=0.
   - Then send a fresh A5 frame: err=0.
5. Timeout and backpressure:
   - Stimulus A: stop after the ADDR byte.
   - Response A: err=1 and busy=0 after exactly 1024 idle cycles.
   - Stimulus B: hold rx_valid=1 continuously through a payload.
   - Response B: rx_ready=0 exactly during the 2 WHOLD cycles; no byte lost.
6. Reset mid-payload:
   - Stimulus: assert reset_n=0 after 2 payload bytes.
   - Response: all outputs return to reset values; no strobe ever asserts; the next frame loads correctly.
